// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed array of leaky integrate-and-fire neurons sharing one datapath
//   clk, reset            clock and synchronous active-high reset
//   cfg_threshold         spike threshold, sampled on each accepted beat
//   cfg_leak_shift        leak = potential >> cfg_leak_shift, sampled on each accepted beat
//   in_valid/in_ready     input handshake; in_current feeds the neuron at the round-robin pointer
//   out_valid/out_ready   result handshake from the single output register stage
//   out_id                index of the neuron that was updated
//   out_spike             the neuron fired on this update
//   out_state             computed potential, before the post-spike reset
//   out_last              the update was for neuron N_NEURONS-1 (end of sweep)
//   Optional macro LIF_REFRACTORY_EN adds per-neuron refractory counters.
module lif_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int STATE_W = 8,
  parameter int IN_W = 6,
  parameter int REFRAC_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [STATE_W-1:0]           cfg_threshold,
  input  logic [2:0]                   cfg_leak_shift,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_current,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_NEURONS)-1:0] out_id,
  output logic                         out_spike,
  output logic [STATE_W-1:0]           out_state,
  output logic                         out_last
);
  localparam int NID_W = $clog2(N_NEURONS);
  localparam logic [NID_W-1:0] LAST_ID = NID_W'(N_NEURONS - 1);
  logic [STATE_W-1:0] pot [N_NEURONS];
  logic [NID_W-1:0] ptr;
  logic accept, refr, spike;
  logic [STATE_W-1:0] leak, sat, sum;
  logic [STATE_W:0] raw;
  assign in_ready = !out_valid | out_ready;
  assign accept = in_valid & in_ready;
  assign leak = 32'(cfg_leak_shift) >= STATE_W ? '0 : pot[ptr] >> cfg_leak_shift;
  // One extra bit catches the carry so the sum saturates instead of wrapping.
  assign raw = (STATE_W+1)'(in_current) + (STATE_W+1)'(leak);
  assign sat = raw[STATE_W] ? '1 : raw[STATE_W-1:0];
  assign sum = refr ? '0 : sat;
  assign spike = !refr && sat >= cfg_threshold;
`ifdef LIF_REFRACTORY_EN
  // Width is kept at least 1 so REFRAC_TICKS=0 still elaborates; the counters then never leave 0.
  localparam int RW = REFRAC_TICKS > 0 ? $clog2(REFRAC_TICKS + 1) : 1;
  logic [RW-1:0] rc [N_NEURONS];
  assign refr = rc[ptr] != '0;
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < N_NEURONS; i++) rc[i] <= '0;
    else if (accept)
      rc[ptr] <= refr ? rc[ptr] - 1'b1 : spike ? RW'(REFRAC_TICKS) : '0;
`else
  assign refr = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) pot[i] <= '0;
      ptr <= '0;
      out_valid <= 1'b0;
      out_id <= '0;
      out_spike <= 1'b0;
      out_state <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      pot[ptr] <= spike ? '0 : sum;
      ptr <= ptr == LAST_ID ? '0 : ptr + 1'b1;
      out_valid <= 1'b1;
      out_id <= ptr;
      out_spike <= spike;
      out_state <= sum;
      out_last <= ptr == LAST_ID;
    end else if (out_ready)
      out_valid <= 1'b0;
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: directed self-checking bench for lif_neuron_array
module tb_lif_neuron_array;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] cfg_threshold = 8'd32;
  logic [2:0] cfg_leak_shift = 3'd1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [5:0] in_current = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [1:0] out_id;
  logic out_spike;
  logic [7:0] out_state;
  logic out_last;
  int n_cmp = 0;
  int n_bad = 0;
  lif_neuron_array dut (
    .clk(clk), .reset(reset), .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_current(in_current),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_spike(out_spike), .out_state(out_state), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [5:0] cur, input int eid, input int est, input logic esp);
    @(negedge clk);
    in_valid = 1'b1;
    in_current = cur;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("id%0d valid", eid), 32'(out_valid), 32'd1);
    chk($sformatf("id%0d id", eid), 32'(out_id), 32'(eid));
    chk($sformatf("id%0d state", eid), 32'(out_state), 32'(est));
    chk($sformatf("id%0d spike", eid), 32'(out_spike), 32'(esp));
    chk($sformatf("id%0d last", eid), 32'(out_last), 32'(eid == 3));
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst id", 32'(out_id), 32'd0);
    chk("rst state", 32'(out_state), 32'd0);
    chk("rst spike", 32'(out_spike), 32'd0);
    chk("rst last", 32'(out_last), 32'd0);
    chk("rst ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    int e2 [4] = '{20, 30, 35, 20};
    int e3 [5] = '{63, 126, 189, 252, 255};
    do_reset();
    for (int i = 0; i < 4; i++) step(6'd0, i, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(6'd20, 0, e2[k], k == 2);
      for (int i = 1; i < 4; i++) step(6'd0, i, 0, 1'b0);
    end
    cfg_leak_shift = 3'd0;
    cfg_threshold = 8'd255;
    for (int k = 0; k < 5; k++) begin
      step(6'd0, 0, 20, 1'b0);
      step(6'd63, 1, e3[k], k == 4);
      step(6'd0, 2, 0, 1'b0);
      step(6'd0, 3, 0, 1'b0);
    end
    cfg_leak_shift = 3'd1;
    cfg_threshold = 8'd32;
    step(6'd0, 0, 10, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_current = 6'd5;
    out_ready = 1'b0;
    #1;
    chk("stall ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall ready", 32'(in_ready), 32'd0);
      chk("stall valid", 32'(out_valid), 32'd1);
      chk("stall id", 32'(out_id), 32'd0);
      chk("stall state", 32'(out_state), 32'd10);
      chk("stall last", 32'(out_last), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("release id", 32'(out_id), 32'd1);
    chk("release state", 32'(out_state), 32'd5);
    chk("release valid", 32'(out_valid), 32'd1);
    step(6'd0, 2, 0, 1'b0);
    step(6'd0, 3, 0, 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(6'd0, 0, 0, 1'b0);
      step(6'd0, 1, 0, 1'b0);
`ifdef LIF_REFRACTORY_EN
      step(6'd63, 2, (k == 1 || k == 2) ? 0 : 63, !(k == 1 || k == 2));
`else
      step(6'd63, 2, 63, 1'b1);
`endif
      step(6'd0, 3, 0, 1'b0);
    end
    do_reset();
    cfg_threshold = 8'd0;
    step(6'd0, 0, 0, 1'b1);
    step(6'd0, 1, 0, 1'b1);
    do_reset();
    step(6'd0, 0, 0, 1'b1);
    step(6'd0, 1, 0, 1'b1);
    step(6'd0, 2, 0, 1'b1);
    step(6'd0, 3, 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
